// File: rtl/seq_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per cycle, MSB first, with a one-cycle out_valid pulse.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               out_valid
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [DW-1:0]    dvd_sr;
  logic [DW-2:0]    quo_sr;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [CW-1:0]    step;

  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] next_rem;
  logic             q_bit;
  logic             last_step;

  // The stored remainder is always below the divisor, so WIDTH bits suffice;
  // the WIDTH+1-bit partial exists only for the compare. A clear borrow bit
  // of the trial subtraction means partial >= divisor.
  always_comb begin
    partial   = {rem_reg, dvd_sr[DW-1]};
    diff      = partial - {1'b0, div_reg};
    q_bit     = ~diff[WIDTH];
    next_rem  = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    last_step = (step == LAST_STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          next_state = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_sr      <= '0;
      quo_sr      <= '0;
      div_reg     <= '0;
      rem_reg     <= '0;
      step        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor != '0) begin
              dvd_sr  <= dividend;
              div_reg <= divisor;
              rem_reg <= '0;
              quo_sr  <= '0;
              step    <= '0;
            end else begin
              quotient    <= '1;
              remainder   <= dividend[WIDTH-1:0];
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          dvd_sr  <= {dvd_sr[DW-2:0], 1'b0};
          quo_sr  <= {quo_sr[DW-3:0], q_bit};
          rem_reg <= next_rem;
          if (last_step) begin
            quotient    <= {quo_sr, q_bit};
            remainder   <= next_rem;
            div_by_zero <= 1'b0;
            step        <= '0;
          end else begin
            step <= step + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, divide by zero,
// back-to-back requests, mid-run reset and a random sweep at WIDTH=8 and 4.
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        v8;
  logic [15:0] dvd8;
  logic [7:0]  dvs8;
  logic        rdy8;
  logic [15:0] q8;
  logic [7:0]  r8;
  logic        z8;
  logic        ov8;

  logic        v4;
  logic [7:0]  dvd4;
  logic [3:0]  dvs4;
  logic        rdy4;
  logic [7:0]  q4;
  logic [3:0]  r4;
  logic        z4;
  logic        ov4;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .dividend(dvd8), .divisor(dvs8),
    .in_ready(rdy8), .quotient(q8), .remainder(r8), .div_by_zero(z8), .out_valid(ov8)
  );

  seq_divider #(.WIDTH(4)) u_div4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .dividend(dvd4), .divisor(dvs4),
    .in_ready(rdy4), .quotient(q4), .remainder(r4), .div_by_zero(z4), .out_valid(ov4)
  );

  // Reference model: plain integer division, with the divide-by-zero convention.
  function automatic void ref8(input logic [15:0] a, input logic [7:0] b,
                               output logic [15:0] q, output logic [7:0] r, output logic z);
    if (b == 0) begin
      q = 16'hFFFF; r = a[7:0]; z = 1'b1;
    end else begin
      q = a / {8'd0, b}; r = 8'(a % {8'd0, b}); z = 1'b0;
    end
  endfunction

  function automatic void ref4(input logic [7:0] a, input logic [3:0] b,
                               output logic [7:0] q, output logic [3:0] r, output logic z);
    if (b == 0) begin
      q = 8'hFF; r = a[3:0]; z = 1'b1;
    end else begin
      q = a / {4'd0, b}; r = 4'(a % {4'd0, b}); z = 1'b0;
    end
  endfunction

  // Drives one request once in_ready is seen, scrambles the operands right
  // after the accept edge, and measures latency up to the out_valid pulse.
  task automatic applyStimulus8(input logic [15:0] a, input logic [7:0] b,
                                output int lat, output int rdy_seen);
    int n = 0;
    rdy_seen = 0;
    @(negedge clk);
    while (!rdy8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rdy8) begin
      errors++;
      $display("[TB] FAIL ready_timeout8: in_ready=%0b required 1", rdy8);
    end
    v8 = 1'b1; dvd8 = a; dvs8 = b;
    @(negedge clk);
    v8 = 1'b0; dvd8 = 16'($urandom); dvs8 = 8'($urandom);
    lat = 1;
    while (!ov8 && lat < 40) begin
      if (rdy8) rdy_seen++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic applyStimulus4(input logic [7:0] a, input logic [3:0] b, output int lat);
    int n = 0;
    @(negedge clk);
    while (!rdy4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rdy4) begin
      errors++;
      $display("[TB] FAIL ready_timeout4: in_ready=%0b required 1", rdy4);
    end
    v4 = 1'b1; dvd4 = a; dvs4 = b;
    @(negedge clk);
    v4 = 1'b0; dvd4 = 8'($urandom); dvs4 = 4'($urandom);
    lat = 1;
    while (!ov4 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v8 = 1'b0; dvd8 = '0; dvs8 = '0;
    v4 = 1'b0; dvd4 = '0; dvs4 = '0;
    #1;
    checks++;
    if ({rdy8, ov8, q8, r8, z8} !== {1'b1, 1'b0, 16'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset8: rdy=%0b ov=%0b q=%0d r=%0d z=%0b required 1 0 0 0 0",
               rdy8, ov8, q8, r8, z8);
    end
    checks++;
    if ({rdy4, ov4, q4, r4, z4} !== {1'b1, 1'b0, 8'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset4: rdy=%0b ov=%0b q=%0d r=%0d z=%0b required 1 0 0 0 0",
               rdy4, ov4, q4, r4, z4);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] ta [3] = '{16'd1000, 16'd65535, 16'd3};
    logic [7:0]  tb [3] = '{8'd7, 8'd255, 8'd200};
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    int lat, rs;
    for (int i = 0; i < 3; i++) begin
      ref8(ta[i], tb[i], eq, er, ez);
      applyStimulus8(ta[i], tb[i], lat, rs);
      checks++;
      if (lat !== 17) begin
        errors++;
        $display("[TB] FAIL latency_dir%0d: got %0d required 17", i, lat);
      end
      checks++;
      if (rs !== 0) begin
        errors++;
        $display("[TB] FAIL ready_in_run%0d: in_ready high %0d cycles required 0", i, rs);
      end
      checks++;
      if ({q8, r8, z8} !== {eq, er, ez}) begin
        errors++;
        $display("[TB] FAIL result_dir%0d: q=%0d r=%0d z=%0b required q=%0d r=%0d z=%0b",
                 i, q8, r8, z8, eq, er, ez);
      end
      @(negedge clk);
      checks++;
      if (ov8 !== 1'b0 || rdy8 !== 1'b1 || q8 !== eq || r8 !== er) begin
        errors++;
        $display("[TB] FAIL hold_dir%0d: ov=%0b rdy=%0b q=%0d r=%0d required 0 1 %0d %0d",
                 i, ov8, rdy8, q8, r8, eq, er);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int lat, rs;
    applyStimulus8(16'd5, 8'd0, lat, rs);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("[TB] FAIL latency_dbz: got %0d required 1", lat);
    end
    checks++;
    if ({q8, r8, z8} !== {16'd65535, 8'd5, 1'b1}) begin
      errors++;
      $display("[TB] FAIL result_dbz: q=%0d r=%0d z=%0b required q=65535 r=5 z=1", q8, r8, z8);
    end
    @(negedge clk);
    checks++;
    if (ov8 !== 1'b0 || rdy8 !== 1'b1 || z8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL after_dbz: ov=%0b rdy=%0b z=%0b required 0 1 1", ov8, rdy8, z8);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q [$];
    logic [7:0]  exp_r [$];
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    int last_acc = -1;
    int accepts = 0;
    int n = 0;
    @(negedge clk);
    v8 = 1'b1;
    for (int c = 0; c < 95; c++) begin
      if (ov8) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL b2b_spurious: out_valid=1 with no pending request, required 0");
        end else begin
          eq = exp_q.pop_front();
          er = exp_r.pop_front();
          if (q8 !== eq || r8 !== er || z8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_result: q=%0d r=%0d z=%0b required q=%0d r=%0d z=0",
                     q8, r8, z8, eq, er);
          end
        end
      end
      dvd8 = 16'($urandom);
      dvs8 = 8'($urandom_range(1, 255));
      if (rdy8) begin
        ref8(dvd8, dvs8, eq, er, ez);
        exp_q.push_back(eq);
        exp_r.push_back(er);
        if (last_acc >= 0) begin
          checks++;
          if (c - last_acc !== 18) begin
            errors++;
            $display("[TB] FAIL b2b_spacing: got %0d required 18", c - last_acc);
          end
        end
        last_acc = c;
        accepts++;
      end
      @(negedge clk);
    end
    v8 = 1'b0;
    while (exp_q.size() != 0 && n < 40) begin
      if (ov8) begin
        eq = exp_q.pop_front();
        er = exp_r.pop_front();
        checks++;
        if (q8 !== eq || r8 !== er) begin
          errors++;
          $display("[TB] FAIL b2b_drain: q=%0d r=%0d required q=%0d r=%0d", q8, r8, eq, er);
        end
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || accepts < 5) begin
      errors++;
      $display("[TB] FAIL b2b_count: pending=%0d accepts=%0d required pending 0 accepts>=5",
               exp_q.size(), accepts);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, rs;
    int pulses = 0;
    @(negedge clk);
    v8 = 1'b1; dvd8 = 16'd1000; dvs8 = 8'd7;
    @(negedge clk);
    v8 = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (ov8) pulses++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy8, ov8, q8, r8, z8} !== {1'b1, 1'b0, 16'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_mid_run: rdy=%0b ov=%0b q=%0d r=%0d z=%0b required 1 0 0 0 0",
               rdy8, ov8, q8, r8, z8);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ov8) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("[TB] FAIL reset_discard: out_valid pulses=%0d required 0", pulses);
    end
    applyStimulus8(16'd200, 8'd13, lat, rs);
    checks++;
    if (lat !== 17 || {q8, r8, z8} !== {16'd15, 8'd5, 1'b0}) begin
      errors++;
      $display("[TB] FAIL after_reset: lat=%0d q=%0d r=%0d z=%0b required 17 15 5 0",
               lat, q8, r8, z8);
    end
  endtask

  task automatic sweep8(input int ops);
    logic [15:0] a, eq;
    logic [7:0]  b, er;
    logic        ez;
    int lat, rs;
    for (int i = 0; i < ops; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      ref8(a, b, eq, er, ez);
      applyStimulus8(a, b, lat, rs);
      checks++;
      if (lat !== ((b == 0) ? 1 : 17) || {q8, r8, z8} !== {eq, er, ez}) begin
        errors++;
        $display("[TB] FAIL sweep8: a=%0d b=%0d lat=%0d q=%0d r=%0d z=%0b required lat=%0d q=%0d r=%0d z=%0b",
                 a, b, lat, q8, r8, z8, (b == 0) ? 1 : 17, eq, er, ez);
      end
      if (b != 0) begin
        checks++;
        if (longint'(q8) * longint'(b) + longint'(r8) != longint'(a) || r8 >= b) begin
          errors++;
          $display("[TB] FAIL invariant8: a=%0d b=%0d q=%0d r=%0d required a=q*b+r and r<b",
                   a, b, q8, r8);
        end
      end
      @(negedge clk);
      checks++;
      if (ov8 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL single_pulse8: out_valid=%0b required 0", ov8);
      end
    end
  endtask

  task automatic sweep4(input int ops);
    logic [7:0] a, eq;
    logic [3:0] b, er;
    logic       ez;
    int lat;
    for (int i = 0; i < ops; i++) begin
      a = 8'($urandom);
      b = 4'($urandom);
      ref4(a, b, eq, er, ez);
      applyStimulus4(a, b, lat);
      checks++;
      if (lat !== ((b == 0) ? 1 : 9) || {q4, r4, z4} !== {eq, er, ez}) begin
        errors++;
        $display("[TB] FAIL sweep4: a=%0d b=%0d lat=%0d q=%0d r=%0d z=%0b required lat=%0d q=%0d r=%0d z=%0b",
                 a, b, lat, q4, r4, z4, (b == 0) ? 1 : 9, eq, er, ez);
      end
      if (b != 0) begin
        checks++;
        if (int'(q4) * int'(b) + int'(r4) != int'(a) || r4 >= b) begin
          errors++;
          $display("[TB] FAIL invariant4: a=%0d b=%0d q=%0d r=%0d required a=q*b+r and r<b",
                   a, b, q4, r4);
        end
      end
      @(negedge clk);
      checks++;
      if (ov4 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL single_pulse4: out_valid=%0b required 0", ov4);
      end
    end
  endtask

  task automatic test_random_sweep();
    fork
      sweep8(3500);
      sweep4(6500);
    join
  endtask

  initial begin
    $display("[TB] starting seq_divider bench");
    test_reset();
    test_directed();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_random_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
